bsg_cache_stream_prefetcher: RTL and testbench



---
 rtl/bsg_cache_stream_prefetcher.sv | 203 ++++++++++++++++++++
 tb/tb_bsg_cache_stream_prefetcher.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cache_stream_prefetcher.sv
// bsg_cache_stream_prefetcher
//   Watches the miss stream of bsg_cache, tracks up to streams_p ascending
//   block-sequential miss streams and, once a stream is confident enough,
//   queues block-aligned prefetch addresses distance_p blocks ahead.
//   Output is a small FIFO with a valid/yumi handshake.
//
//   Optional build macro: BSG_CACHE_STREAM_PREFETCHER_DEDUP_EN
//     defined   -> a qualified prefetch already present in the FIFO is dropped
//                  silently (no drop_o pulse, no enqueue).
//     undefined -> duplicates may be enqueued.
module bsg_cache_stream_prefetcher #(
  parameter int addr_width_p          = 30,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int streams_p             = 4,
  parameter int threshold_p           = 2,
  parameter int distance_p            = 2,
  parameter int fifo_els_p            = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    miss_v_i,
  input  logic [addr_width_p-1:0] miss_addr_i,
  output logic [addr_width_p-1:0] pf_addr_o,
  output logic                    pf_v_o,
  input  logic                    pf_yumi_i,
  output logic                    drop_o
);

  localparam int offset_lp = $clog2(block_size_in_words_p * data_width_p / 8);
  localparam int blk_w_lp  = addr_width_p - offset_lp;
  localparam int blkx_w_lp = blk_w_lp + 1;
  localparam int sptr_w_lp = $clog2(streams_p);
  localparam int fptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp  = $clog2(fifo_els_p + 1);

  localparam logic [1:0]           thresh_lp    = 2'(threshold_p);
  localparam logic [blkx_w_lp-1:0] dist_lp      = blkx_w_lp'(distance_p);
  localparam logic [cnt_w_lp-1:0]  full_cnt_lp  = cnt_w_lp'(fifo_els_p);
  localparam logic [fptr_w_lp-1:0] last_slot_lp = fptr_w_lp'(fifo_els_p - 1);

  typedef struct packed {
    logic                valid;
    logic [blk_w_lp-1:0] exp_blk;  // next block this stream is expected to miss on
    logic [1:0]          conf;     // saturating confidence
  } entry_t;

  // ---------------------------------------------------------------------------
  // Stream table
  // ---------------------------------------------------------------------------
  entry_t               tbl [streams_p];
  logic [sptr_w_lp-1:0] alloc_ptr;

  logic [blk_w_lp-1:0]  blk;
  logic [blkx_w_lp-1:0] blk_inc;
  logic [blkx_w_lp-1:0] blk_pf;
  logic                 inc_ovf;
  logic                 pf_ovf;
  logic                 hit;
  logic [sptr_w_lp-1:0] hit_idx;
  logic [1:0]           conf_cur;
  logic [1:0]           conf_new;
  logic [sptr_w_lp-1:0] wr_idx;
  entry_t               wr_entry;
  logic                 qualify;

  // Offset bits only select bytes within a block; they never affect tracking.
  logic unused_offset;
  assign unused_offset = ^miss_addr_i[offset_lp-1:0];

  assign blk     = miss_addr_i[addr_width_p-1:offset_lp];
  // One extra bit catches wrap past the top block.
  assign blk_inc = {1'b0, blk} + blkx_w_lp'(1);
  assign blk_pf  = {1'b0, blk} + dist_lp;
  assign inc_ovf = blk_inc[blk_w_lp];
  assign pf_ovf  = blk_pf[blk_w_lp];

  // Parallel lookup; iterating downward lets the lowest matching index win.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment so no path leaves it unassigned (which would infer a latch).
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = streams_p - 1; i >= 0; i--) begin
      if (tbl[i].valid && (tbl[i].exp_blk == blk)) begin
        hit     = 1'b1;
        hit_idx = sptr_w_lp'(i);
      end
    end
  end

  assign conf_cur = tbl[hit_idx].conf;
  assign conf_new = (conf_cur == 2'd3) ? 2'd3 : conf_cur + 2'd1;

  // A hit refreshes its own entry; a miss replaces the round-robin victim.
  // Either way the stream now expects blk+1, unless that wrapped.
  assign wr_idx   = hit ? hit_idx : alloc_ptr;
  assign wr_entry = '{valid:   ~inc_ovf,
                      exp_blk: blk_inc[blk_w_lp-1:0],
                      conf:    hit ? conf_new : 2'd0};

  assign qualify = miss_v_i & hit & (conf_new >= thresh_lp) & ~pf_ovf;

  // Table update and allocation pointer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < streams_p; i++) begin
        tbl[i] <= '0;
      end
      alloc_ptr <= '0;
    end else if (miss_v_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      tbl[wr_idx] <= wr_entry;
      if (!hit) begin
        alloc_ptr <= alloc_ptr + sptr_w_lp'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [blk_w_lp-1:0]  mem [fifo_els_p];
  logic [fptr_w_lp-1:0] rd_ptr;
  logic [fptr_w_lp-1:0] wr_ptr;
  logic [cnt_w_lp-1:0]  count;
  logic                 full;
  logic                 deq;
  logic                 dup;
  logic                 enq_req;
  logic                 enq;

  assign full = (count == full_cnt_lp);
  assign deq  = pf_yumi_i & pf_v_o;

`ifdef BSG_CACHE_STREAM_PREFETCHER_DEDUP_EN
  // Match the candidate against every occupied slot, including the head that
  // may be leaving this very cycle.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < fifo_els_p; i++) begin
      if ((((i >= int'(rd_ptr)) ? (i - int'(rd_ptr))
                                : (i + fifo_els_p - int'(rd_ptr))) < int'(count))
          && (mem[i] == blk_pf[blk_w_lp-1:0])) begin
        dup = 1'b1;
      end
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign enq_req = qualify & ~dup;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign enq     = enq_req & (~full | deq);

  // FIFO storage: written only on enqueue, read only when occupied.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is deliberately not reset; occupancy is tracked
    // by count and the output is gated, so stale contents are never observed.
    if (enq) begin
      mem[wr_ptr] <= blk_pf[blk_w_lp-1:0];
    end
  end

  // FIFO pointers, occupancy and the registered drop pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      drop_o <= 1'b0;
    end else begin
      drop_o <= enq_req & full & ~deq;
      if (enq) begin
        wr_ptr <= (wr_ptr == last_slot_lp) ? '0 : wr_ptr + fptr_w_lp'(1);
      end
      if (deq) begin
        rd_ptr <= (rd_ptr == last_slot_lp) ? '0 : rd_ptr + fptr_w_lp'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + cnt_w_lp'(1);
        2'b01:   count <= count - cnt_w_lp'(1);
        default: count <= count;
      endcase
    end
  end

  assign pf_v_o    = (count != '0);
  assign pf_addr_o = pf_v_o ? {mem[rd_ptr], {offset_lp{1'b0}}} : '0;

`ifndef SYNTHESIS
  // Consumer must not take from an empty FIFO.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(pf_yumi_i && !pf_v_o))
        else $error("bsg_cache_stream_prefetcher: pf_yumi_i asserted while pf_v_o is 0");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_cache_stream_prefetcher.sv
// Testbench for bsg_cache_stream_prefetcher: directed scenarios followed by
// randomized miss streams, all checked against a behavioural model through a
// scoreboard queue drained by an independent monitor.
module tb_bsg_cache_stream_prefetcher;

  localparam int AW = 30;
  localparam longint unsigned MAXB = (64'd1 << 25) - 1;  // top block number

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          miss_v_i = 1'b0;
  logic [AW-1:0] miss_addr_i = '0;
  logic          pf_yumi_i = 1'b0;
  logic [AW-1:0] pf_addr_o;
  logic          pf_v_o;
  logic          drop_o;

  bsg_cache_stream_prefetcher dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .miss_v_i    (miss_v_i),
    .miss_addr_i (miss_addr_i),
    .pf_addr_o   (pf_addr_o),
    .pf_v_o      (pf_v_o),
    .pf_yumi_i   (pf_yumi_i),
    .drop_o      (drop_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          v;
    logic [AW-1:0] addr;
    bit          drop;
  } exp_t;

  exp_t sb[$];

  // Reference model: streams as plain arrays of block numbers, FIFO as a queue.
  bit              m_val  [4];
  longint unsigned m_exp  [4];
  int              m_conf [4];
  int              m_ptr;
  longint unsigned m_fifo [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Predict the outputs that follow one clock edge with the given inputs.
  task automatic model(input bit rst, input bit mv, input logic [AW-1:0] a,
                       input bit y, output exp_t e);
    longint unsigned b;
    int  hit;
    bit  qual;
    bit  full_before;
    e.drop = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_val[i] = 1'b0; m_exp[i] = 0; m_conf[i] = 0;
      end
      m_ptr = 0;
      m_fifo.delete();
    end else begin
      qual = 1'b0;
      full_before = (m_fifo.size() == 4);
      if (mv) begin
        b = longint'(a) >> 5;
        hit = -1;
        for (int i = 0; i < 4; i++)
          if (hit < 0 && m_val[i] && m_exp[i] == b) hit = i;
        if (hit >= 0) begin
          m_conf[hit] = (m_conf[hit] >= 3) ? 3 : m_conf[hit] + 1;
          m_val[hit]  = (b != MAXB);
          m_exp[hit]  = (b + 1) & MAXB;
          qual = (m_conf[hit] >= 2) && (b + 2 <= MAXB);
        end else begin
          m_val[m_ptr]  = (b != MAXB);
          m_exp[m_ptr]  = (b + 1) & MAXB;
          m_conf[m_ptr] = 0;
          m_ptr = (m_ptr + 1) % 4;
        end
`ifdef BSG_CACHE_STREAM_PREFETCHER_DEDUP_EN
        foreach (m_fifo[k]) if (m_fifo[k] == b + 2) qual = 1'b0;
`endif
      end
      if (y) void'(m_fifo.pop_front());
      if (qual) begin
        if (full_before && !y) e.drop = 1'b1;
        else m_fifo.push_back(b + 2);
      end
    end
    e.v    = (m_fifo.size() > 0);
    e.addr = e.v ? AW'(m_fifo[0] << 5) : '0;
  endtask

  // Apply one cycle of stimulus; leaves time at posedge+1 with outputs settled.
  task automatic step(input bit rst, input bit mv, input logic [AW-1:0] a, input bit want_y);
    exp_t e;
    bit   y;
    y = want_y && !rst && (m_fifo.size() > 0);
    reset_i     = rst;
    miss_v_i    = mv;
    miss_addr_i = a;
    pf_yumi_i   = y;
    model(rst, mv, a, y, e);
    @(posedge clk_i);
    #1;
    sb.push_back(e);
    reset_i   = 1'b0;
    miss_v_i  = 1'b0;
    pf_yumi_i = 1'b0;
  endtask

  task automatic stream_confirm();
    step(0, 1, 30'h100, 1);
    step(0, 1, 30'h120, 1);
    check("sc_v_before", 32'(pf_v_o), 32'd0);
    step(0, 1, 30'h140, 1);
    check("sc_v_first", 32'(pf_v_o), 32'd1);
    check("sc_addr_180", 32'(pf_addr_o), 32'h180);
    step(0, 1, 30'h160, 1);
    check("sc_addr_1a0", 32'(pf_addr_o), 32'h1A0);
    step(0, 0, '0, 1);
    check("sc_drained", 32'(pf_v_o), 32'd0);
  endtask

  // Monitor: compares DUT outputs against the scoreboard, one entry per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pf_v",    32'(pf_v_o),    32'(e.v));
        check("pf_addr", 32'(pf_addr_o), 32'(e.addr));
        check("drop",    32'(drop_o),    32'(e.drop));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int drops;
    logic [31:0] drain_exp [4];
    longint unsigned cur [3];

    // Reset state
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    check("rst_v",    32'(pf_v_o),    32'd0);
    check("rst_addr", 32'(pf_addr_o), 32'd0);
    check("rst_drop", 32'(drop_o),    32'd0);

    // Stream confirm
    stream_confirm();

    // Unaligned input
    step(1, 0, '0, 0);
    step(0, 1, 30'h104, 1);
    step(0, 1, 30'h13C, 1);
    step(0, 1, 30'h15F, 1);
    check("ua_addr", 32'(pf_addr_o), 32'h180);
    step(0, 0, '0, 1);
    check("ua_single", 32'(pf_v_o), 32'd0);

    // Round-robin replacement restarts the 0x1000 stream at conf 0
    step(1, 0, '0, 0);
    for (int i = 1; i <= 5; i++) step(0, 1, AW'(i * 32'h1000), 0);
    step(0, 1, 30'h1020, 0);
    step(0, 1, 30'h1040, 0);
    check("rr_no_pf", 32'(pf_v_o), 32'd0);

    // Full / drop
    step(1, 0, '0, 0);
    drops = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, AW'(i * 32), 0);
      if (drop_o) drops++;
    end
    check("fd_drop_count", 32'(drops), 32'd2);
    drain_exp = '{32'h80, 32'hA0, 32'hC0, 32'hE0};
    for (int i = 0; i < 4; i++) begin
      check("fd_drain", 32'(pf_addr_o), drain_exp[i]);
      step(0, 0, '0, 1);
    end
    check("fd_empty", 32'(pf_v_o), 32'd0);

    // Simultaneous enqueue/dequeue on a full FIFO
    step(1, 0, '0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, AW'(i * 32), 0);
    step(0, 1, 30'h100, 1);
    check("sim_no_drop", 32'(drop_o), 32'd0);
    drain_exp = '{32'hA0, 32'hC0, 32'hE0, 32'h140};
    for (int i = 0; i < 4; i++) begin
      check("sim_drain", 32'(pf_addr_o), drain_exp[i]);
      step(0, 0, '0, 1);
    end
    check("sim_empty", 32'(pf_v_o), 32'd0);

    // Reset mid-operation, then identical stream confirm
    step(1, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, AW'(32'h100 + i * 32), 0);
    check("mid_queued", 32'(pf_v_o), 32'd1);
    step(1, 0, '0, 0);
    check("mid_rst_v", 32'(pf_v_o), 32'd0);
    stream_confirm();

    // Wrap at the top of the address space
    step(1, 0, '0, 0);
    step(0, 1, 30'h3FFFFFA0, 0);
    step(0, 1, 30'h3FFFFFC0, 0);
    step(0, 1, 30'h3FFFFFE0, 0);
    check("wrap_v",    32'(pf_v_o), 32'd0);
    check("wrap_drop", 32'(drop_o), 32'd0);

    // Randomized interleaved streams
    cur = '{64'h40, 64'h8000, MAXB - 6};
    for (int n = 0; n < 1500; n++) begin
      int s;
      logic [AW-1:0] a;
      s = $urandom_range(0, 2);
      a = AW'(cur[s] << 5) | AW'($urandom_range(0, 31));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), a,
           ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 3) == 0) cur[s] = MAXB - $urandom_range(0, 4);
        else cur[s] = longint'($urandom_range(0, 32'h1FFFFFF));
      end else begin
        cur[s] = (cur[s] == MAXB) ? 0 : cur[s] + 1;
      end
    end

    repeat (3) @(negedge clk_i);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
